imem_loader: RTL and testbench
==============================

// Module: imem_loader
//
// PURPOSE
//  Writer side of the instruction-memory read path. Receives a program image as a
//  byte stream (valid/ready), packs it into big-endian 32-bit words and drives the
//  instruction-memory write port. The packing matches the fetch order:
//  byte at addr -> [31:24], addr+3 -> [7:0].
//  Holds the CPU in reset until a checksum-verified image is fully written.
//
// PARAMETERS
//  MEM_BYTES  128  instruction memory size in bytes
//  ADDR_W     7    byte-address width (log2 MEM_BYTES)
//  MAX_WORDS  32   MEM_BYTES/4; largest legal word count
//
// PORTS
//  clk           in   1       clock, rising edge
//  reset         in   1       asynchronous, active-high
//  start         in   1       1-cycle pulse: begin a load (honoured only in IDLE/DONE/ERR)
//  in_valid      in   1       stream byte valid
//  in_data       in   8       stream byte
//  in_ready      out  1       loader accepts byte (handshake = in_valid & in_ready)
//  wr_en         out  1       imem write strobe, one cycle per word
//  wr_addr       out  ADDR_W  byte address of word (always multiple of 4)
//  wr_data       out  32      big-endian packed word
//  cpu_reset     out  1       hold to CPU; 1 until verified load completes
//  busy          out  1       1 in LEN/DATA/CSUM
//  done          out  1       1 in DONE
//  err           out  1       1 in ERR
//  words_loaded  out  6       words written in current/last load
//
// BEHAVIOUR
//  - Reset (async): state=IDLE, cpu_reset=1, all other outputs 0, counters/checksum cleared.
//  - States:
//    - IDLE: in_ready=0; start -> LEN.
//    - LEN: in_ready=1; accepted byte N.
//      N==0 or N>MAX_WORDS -> ERR; else latch N, word_idx=0, byte_idx=0, csum=0 -> DATA.
//    - DATA: in_ready=1; each accepted byte b: csum^=b; b placed at lane byte_idx
//      (0->[31:24] .. 3->[7:0]); byte_idx++ mod 4.
//      On the 4th byte: in the next cycle wr_en=1 for exactly one cycle,
//      wr_addr=word_idx*4, wr_data=packed word; word_idx++.
//      After word N-1's 4th byte -> CSUM.
//      Back-to-back bytes every cycle are legal, with no stall.
//    - CSUM: in_ready=1; accepted byte == csum (XOR of payload bytes only, not N) -> DONE; else -> ERR.
//    - DONE: cpu_reset=0, done=1, in_ready=0; start -> LEN.
//    - ERR: cpu_reset=1, err=1, in_ready=0; start -> LEN.
//  - cpu_reset, done, err and busy are registered.
//    On a start from DONE/ERR: cpu_reset=1 and done/err=0 from the cycle LEN is entered.
//  - start while busy: ignored.
//    in_valid with in_ready=0: byte not consumed, no state change.
//  - words_loaded = word_idx; it clears on entry to LEN and holds in DONE/ERR.
//  - Address wrap is impossible: N<=MAX_WORDS, so the maximum wr_addr is MEM_BYTES-4.
//  - Reset mid-load: return to IDLE immediately. Words already written stay in memory;
//    cpu_reset stays 1.
//  - No cycle after the final data byte is lost: the last wr_en may coincide with the
//    CSUM handshake.
//
// TESTING
//  1. Reset, start, stream 01 | DE AD BE EF | 22 (checksum: DE^AD^BE^EF=22)
//     -> single wr_en, addr 0x00, data 0xDEADBEEF; then done=1, cpu_reset=0, words_loaded=1.
//  2. N=3, words 0x00000001/0x00000002/0x00000003, valid every cycle
//     -> wr_en at addr 0x00/0x04/0x08 with matching data; DONE (checksum 0x00).
//  3. Test 1 with a bad checksum byte 0x23 -> err=1, cpu_reset=1, done=0; then start again
//     and a good image -> DONE.
//  4. Length byte 0x00, then length byte 0x21 (33)
//     -> ERR immediately each time, no wr_en.
//  5. N=32, randomised in_valid gaps -> 32 writes, addresses 0x00..0x7C, all words match.
//  6. Assert reset after 2 of 4 words -> IDLE next edge, no further wr_en; start while busy
//     and in_valid with in_ready=0 have no effect.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
//   Receives a program image as a byte stream and writes it into instruction
//   memory as big-endian 32-bit words. The CPU is held in reset until a
//   checksum-verified image has been completely written.
//
//   Image format: N (word count, 1..MAX_WORDS), 4*N payload bytes, then one
//   checksum byte equal to the XOR of the payload bytes.
//
//   Handshake: a byte is consumed on a rising clock edge where in_valid and
//   in_ready are both 1; when in_ready is 0 the byte is left untouched.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   start               one-cycle pulse, begins a load from IDLE/DONE/ERR
//   in_valid, in_data   byte stream source
//   in_ready            loader can take a byte (LEN/DATA/CSUM)
//   wr_en/addr/data     imem write port, one strobe per packed word
//   cpu_reset           1 until a verified load completes
//   busy, done, err     registered status flags
//   words_loaded        words written in the current or last load
module imem_loader #(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 7,
    parameter int MAX_WORDS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [5:0]        words_loaded
);

    // The length limit never exceeds what the memory can hold.
    localparam int         LIMIT_WORDS = (MEM_BYTES / 4 < MAX_WORDS) ? MEM_BYTES / 4 : MAX_WORDS;
    localparam logic [7:0] LIMIT_8     = 8'(LIMIT_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state, state_nx;
    logic [5:0]  n_words;
    logic [5:0]  word_idx;
    logic [1:0]  byte_idx;
    logic [7:0]  csum;
    logic [23:0] word_buf;   // first three bytes of the word being assembled
    logic        accept;

    assign accept       = in_valid & in_ready;
    assign words_loaded = word_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_LEN;
            end
            S_LEN: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (in_data == 8'd0 || in_data > LIMIT_8) state_nx = S_ERR;
                    else                                      state_nx = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (accept && byte_idx == 2'd3 && word_idx == n_words - 6'd1)
                    state_nx = S_CSUM;
            end
            S_CSUM: begin
                in_ready = 1'b1;
                if (accept) state_nx = (in_data == csum) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: begin
                if (start) state_nx = S_LEN;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath and status flags. Flags are computed from the next state so
    // that they change on the same edge as the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            n_words   <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            csum      <= '0;
            word_buf  <= '0;
        end else begin
            wr_en     <= 1'b0;
            busy      <= (state_nx == S_LEN) || (state_nx == S_DATA) || (state_nx == S_CSUM);
            done      <= (state_nx == S_DONE);
            err       <= (state_nx == S_ERR);
            cpu_reset <= (state_nx != S_DONE);

            if (state != S_LEN && state_nx == S_LEN) begin
                word_idx <= '0;
                byte_idx <= '0;
                csum     <= '0;
            end

            if (state == S_LEN && accept) begin
                n_words <= in_data[5:0];
            end

            if (state == S_DATA && accept) begin
                csum     <= csum ^ in_data;
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0:    word_buf[23:16] <= in_data;
                    2'd1:    word_buf[15:8]  <= in_data;
                    2'd2:    word_buf[7:0]   <= in_data;
                    default: begin
                        // Fourth byte goes straight into the write word so the
                        // strobe fires on the very next cycle.
                        wr_en    <= 1'b1;
                        wr_addr  <= ADDR_W'({word_idx, 2'b00});
                        wr_data  <= {word_buf, in_data};
                        word_idx <= word_idx + 6'd1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;
  logic [5:0]  words_loaded;

  int vectors = 0;
  int miscompares = 0;

  // Expected writes: {addr[6:0], data[31:0]}
  logic [38:0] exp_q[$];
  logic [38:0] exp_head;

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 64'(wr_en), 64'd0);
      end else begin
        exp_head = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(exp_head[38:32]));
        check("wr_data", 64'(wr_data), 64'(exp_head[31:0]));
      end
    end
  end

  // drivers
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit with_start);
    int guard;
    if ($urandom_range(0, 99) < gap_pct) begin
      repeat ($urandom_range(1, 3)) begin
        in_data = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      check("handshake_timeout", 64'(in_ready), 64'd1);
    end else begin
      start = with_start;
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  // Reference model: predicts the writes and the final status of one image
  // directly from the image format, then drives it and checks the outcome.
  task automatic run_image(input logic [7:0] len, input logic [7:0] pl[$],
                           input logic [7:0] csum_byte, input int gap_pct,
                           input bit poke_start);
    bit         len_ok;
    bit         good;
    logic [7:0] x;
    len_ok = (len >= 8'd1) && (len <= 8'd32);
    x = 8'h00;
    if (len_ok) begin
      for (int w = 0; w < int'(len); w++) begin
        exp_q.push_back({7'(w * 4), pl[4*w], pl[4*w+1], pl[4*w+2], pl[4*w+3]});
        x = x ^ pl[4*w] ^ pl[4*w+1] ^ pl[4*w+2] ^ pl[4*w+3];
      end
    end
    good = len_ok && (csum_byte == x);

    pulse_start();
    check("busy_after_start", 64'(busy), 64'd1);
    check("cpu_reset_after_start", 64'(cpu_reset), 64'd1);
    check("flags_after_start", 64'({done, err}), 64'd0);

    send_byte(len, gap_pct, 1'b0);
    if (len_ok) begin
      for (int i = 0; i < pl.size(); i++) send_byte(pl[i], gap_pct, poke_start && (i == 5));
      send_byte(csum_byte, gap_pct, 1'b0);
    end
    repeat (2) begin @(posedge clk); #1; end

    check("done", 64'(done), 64'(good));
    check("err", 64'(err), 64'(!good));
    check("cpu_reset", 64'(cpu_reset), 64'(!good));
    check("busy_end", 64'(busy), 64'd0);
    check("in_ready_end", 64'(in_ready), 64'd0);
    check("words_loaded", 64'(words_loaded), len_ok ? 64'(len) : 64'd0);
    check("pending_wr", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic random_payload(input int n, output logic [7:0] pl[$], output logic [7:0] x);
    pl = {};
    x  = 8'h00;
    for (int i = 0; i < n * 4; i++) begin
      pl.push_back(8'($urandom_range(0, 255)));
      x = x ^ pl[i];
    end
  endtask

  logic [7:0] pl[$];
  logic [7:0] xs;
  logic [7:0] len;

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_flags", 64'({busy, done, err, wr_en, in_ready}), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // single word
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_image(8'd1, pl, 8'h22, 0, 1'b0);

    // three words, back-to-back
    pl = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03};
    run_image(8'd3, pl, 8'h00, 0, 1'b0);

    // bad checksum, then recovery
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_image(8'd1, pl, 8'h23, 0, 1'b0);
    run_image(8'd1, pl, 8'h22, 0, 1'b0);

    // illegal lengths
    pl = {};
    run_image(8'd0, pl, 8'h00, 0, 1'b0);
    run_image(8'h21, pl, 8'h00, 0, 1'b0);

    // full memory with gaps
    random_payload(32, pl, xs);
    run_image(8'd32, pl, xs, 40, 1'b0);

    // random images; start pulsed mid-payload must be ignored
    for (int k = 0; k < 8; k++) begin
      len = 8'($urandom_range(0, 36));
      if (len >= 8'd1 && len <= 8'd32) random_payload(int'(len), pl, xs);
      else begin pl = {}; xs = 8'h00; end
      if ($urandom_range(0, 3) == 0) xs = xs ^ 8'($urandom_range(1, 255));
      run_image(len, pl, xs, $urandom_range(0, 50), len >= 8'd2 && len <= 8'd32);
    end

    // reset after two of four words
    random_payload(4, pl, xs);
    pulse_start();
    send_byte(8'd4, 0, 1'b0);
    for (int w = 0; w < 2; w++)
      exp_q.push_back({7'(w * 4), pl[4*w], pl[4*w+1], pl[4*w+2], pl[4*w+3]});
    for (int i = 0; i < 8; i++) send_byte(pl[i], 0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_words", 64'(words_loaded), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    // bytes offered while idle are not consumed
    in_valid = 1'b1;
    in_data  = 8'h05;
    repeat (5) begin @(posedge clk); #1; end
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_in_ready", 64'(in_ready), 64'd0);
    check("idle_cpu_reset", 64'(cpu_reset), 64'd1);
    in_valid = 1'b0;
    check("midrst_pending", 64'(exp_q.size()), 64'd0);

    // loader still works afterwards
    random_payload(2, pl, xs);
    run_image(8'd2, pl, xs, 20, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
